// File: rtl/mips_multi_cycle.sv
// ============================================================================
// Module   : mips_multi_cycle
// Purpose  : Multi-cycle MIPS-I subset core with one unified memory port.
//            Every instruction moves through FETCH, DECODE, EXECUTE and then,
//            if it needs them, MEMORY and WRITEBACK. Unsupported instructions
//            and misaligned loads/stores send the core to HALT. HALT is left
//            only by reset.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          : clock; all state changes happen on the rising edge
//   reset        : asynchronous, active-low reset
//   mem_req_o    : memory access request
//   mem_we_o     : 1 = write, 0 = read
//   mem_addr_o   : word-aligned byte address
//   mem_wdata_o  : store data
//   mem_rdata_i  : read data, valid when mem_ready_i = 1
//   mem_ready_i  : the access completes in a cycle where this is high
//   alu_result_o : registered ALU result (ALUOut)
//   halt_o       : core stopped on a fault
//   cycle_count_o, instr_count_o : performance counters, present only
//                  when MIPS_MC_PERF_EN is defined
// Configuration
//   MIPS_MC_PERF_EN : adds the cycle and instruction counters
// ============================================================================
`default_nettype none

module mips_multi_cycle #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] SP_INIT  = 32'h7FFF_EFFC,
  parameter logic [31:0] GP_INIT  = 32'h1000_8000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i,
  output logic [31:0] alu_result_o,
  output logic        halt_o
`ifdef MIPS_MC_PERF_EN
  ,
  output logic [31:0] cycle_count_o,
  output logic [31:0] instr_count_o
`endif
);

  typedef enum logic [2:0] {
    S_INIT      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_e;

  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_j     = 6'h02;
  localparam logic [5:0] c_op_jal   = 6'h03;
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_bne   = 6'h05;
  localparam logic [5:0] c_op_addi  = 6'h08;
  localparam logic [5:0] c_op_ori   = 6'h0D;
  localparam logic [5:0] c_op_lui   = 6'h0F;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2B;

  localparam logic [5:0] c_fn_sll   = 6'h00;
  localparam logic [5:0] c_fn_jr    = 6'h08;
  localparam logic [5:0] c_fn_add   = 6'h20;
  localparam logic [5:0] c_fn_sub   = 6'h22;
  localparam logic [5:0] c_fn_and   = 6'h24;
  localparam logic [5:0] c_fn_or    = 6'h25;
  localparam logic [5:0] c_fn_nor   = 6'h27;
  localparam logic [5:0] c_fn_slt   = 6'h2A;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] alu_out_q, alu_out_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] target_q, target_d;
  logic [31:0] rf_q [0:31];

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  // Instruction fields, always taken from the latched IR
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] imm26;
  logic [31:0] sext_imm, zext_imm;
  logic [31:0] rs_val, rt_val;
  logic [31:0] alu_res;
  logic        legal;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign imm      = ir_q[15:0];
  assign imm26    = ir_q[25:0];
  assign sext_imm = {{16{imm[15]}}, imm};
  assign zext_imm = {16'h0000, imm};

  // $0 reads as zero regardless of array contents
  assign rs_val = (rs == 5'd0) ? 32'h0 : rf_q[rs];
  assign rt_val = (rt == 5'd0) ? 32'h0 : rf_q[rt];

  always_comb begin
    legal = 1'b0;
    if (opcode == c_op_rtype) begin
      case (funct)
        c_fn_add, c_fn_sub, c_fn_and, c_fn_or,
        c_fn_nor, c_fn_slt, c_fn_sll, c_fn_jr: legal = 1'b1;
        default:                               legal = 1'b0;
      endcase
    end else begin
      case (opcode)
        c_op_addi, c_op_ori, c_op_lui, c_op_lw, c_op_sw,
        c_op_beq, c_op_bne, c_op_j, c_op_jal: legal = 1'b1;
        default:                              legal = 1'b0;
      endcase
    end
  end

  // ALU: R-type operations, immediates and load/store address generation
  always_comb begin
    alu_res = a_q + sext_imm;
    if (opcode == c_op_rtype) begin
      case (funct)
        c_fn_add: alu_res = a_q + b_q;
        c_fn_sub: alu_res = a_q - b_q;
        c_fn_and: alu_res = a_q & b_q;
        c_fn_or:  alu_res = a_q | b_q;
        c_fn_nor: alu_res = ~(a_q | b_q);
        c_fn_slt: alu_res = {31'h0, ($signed(a_q) < $signed(b_q))};
        c_fn_sll: alu_res = b_q << shamt;
        default:  alu_res = a_q + b_q;
      endcase
    end else begin
      case (opcode)
        c_op_ori: alu_res = a_q | zext_imm;
        c_op_lui: alu_res = {imm, 16'h0000};
        default:  alu_res = a_q + sext_imm;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    alu_out_d   = alu_out_q;
    mdr_d       = mdr_q;
    target_d    = target_q;
    rf_we       = 1'b0;
    rf_waddr    = 5'd0;
    rf_wdata    = 32'h0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;

    case (state_q)
      S_INIT: state_d = S_FETCH;

      S_FETCH: begin
        mem_req_o  = 1'b1;
        mem_addr_o = pc_q;
        if (mem_ready_i) begin
          ir_d    = mem_rdata_i;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        a_d      = rs_val;
        b_d      = rt_val;
        // pc_q already points past this instruction
        target_d = pc_q + (sext_imm << 2);
        state_d  = legal ? S_EXECUTE : S_HALT;
      end

      S_EXECUTE: begin
        state_d = S_FETCH;
        if (opcode == c_op_rtype) begin
          if (funct == c_fn_jr) begin
            pc_d = a_q;
          end else begin
            alu_out_d = alu_res;
            state_d   = S_WRITEBACK;
          end
        end else begin
          case (opcode)
            c_op_j: pc_d = {pc_q[31:28], imm26, 2'b00};
            c_op_jal: begin
              pc_d     = {pc_q[31:28], imm26, 2'b00};
              rf_we    = 1'b1;
              rf_waddr = 5'd31;
              rf_wdata = pc_q;
            end
            c_op_beq: if (a_q == b_q) pc_d = target_q;
            c_op_bne: if (a_q != b_q) pc_d = target_q;
            c_op_lw, c_op_sw: begin
              alu_out_d = alu_res;
              // A misaligned address halts before any request is issued
              state_d   = (alu_res[1:0] != 2'b00) ? S_HALT : S_MEMORY;
            end
            default: begin
              alu_out_d = alu_res;
              state_d   = S_WRITEBACK;
            end
          endcase
        end
      end

      S_MEMORY: begin
        mem_req_o  = 1'b1;
        mem_addr_o = alu_out_q;
        if (opcode == c_op_sw) begin
          mem_we_o    = 1'b1;
          mem_wdata_o = b_q;
        end
        if (mem_ready_i) begin
          if (opcode == c_op_lw) begin
            mdr_d   = mem_rdata_i;
            state_d = S_WRITEBACK;
          end else begin
            state_d = S_FETCH;
          end
        end
      end

      S_WRITEBACK: begin
        rf_we = 1'b1;
        if (opcode == c_op_rtype) begin
          rf_waddr = rd;
          rf_wdata = alu_out_q;
        end else begin
          rf_waddr = rt;
          rf_wdata = (opcode == c_op_lw) ? mdr_q : alu_out_q;
        end
        state_d = S_FETCH;
      end

      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_INIT;
      pc_q      <= RESET_PC;
      ir_q      <= 32'h0;
      a_q       <= 32'h0;
      b_q       <= 32'h0;
      alu_out_q <= 32'h0;
      mdr_q     <= 32'h0;
      target_q  <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      mdr_q     <= mdr_d;
      target_q  <= target_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        if (i == 28)      rf_q[i] <= GP_INIT;
        else if (i == 29) rf_q[i] <= SP_INIT;
        else              rf_q[i] <= 32'h0;
      end
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  assign alu_result_o = alu_out_q;
  assign halt_o       = (state_q == S_HALT);

`ifdef MIPS_MC_PERF_EN
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [31:0] instr_count_q, instr_count_d;

  // An instruction completes on any return to FETCH other than from INIT
  always_comb begin
    cycle_count_d = cycle_count_q;
    instr_count_d = instr_count_q;
    if ((state_q != S_INIT) && (state_q != S_HALT))
      cycle_count_d = cycle_count_q + 32'd1;
    if ((state_d == S_FETCH) && (state_q != S_INIT) && (state_q != S_FETCH))
      instr_count_d = instr_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count_q <= 32'h0;
      instr_count_q <= 32'h0;
    end else begin
      cycle_count_q <= cycle_count_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign cycle_count_o = cycle_count_q;
  assign instr_count_o = instr_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mips_multi_cycle.sv
// ============================================================================
// Module   : tb_mips_multi_cycle
// Purpose  : Directed self-checking bench for mips_multi_cycle. A small
//            memory model answers requests with a programmable data-side
//            latency, and a monitor logs the address and cycle of every
//            instruction fetch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_multi_cycle;

  localparam logic [31:0] c_reset_pc = 32'h0040_0000;
  localparam logic [31:0] c_gp       = 32'h1000_8000;
  localparam logic [31:0] c_sp       = 32'h7FFF_EFFC;
  localparam logic [31:0] c_undef    = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req_o, mem_we_o, halt_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i, alu_result_o;
  logic        mem_ready_i;
`ifdef MIPS_MC_PERF_EN
  logic [31:0] cycle_count_o, instr_count_o;
`endif

  mips_multi_cycle dut (
    .clk          (clk),
    .reset        (reset),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ready_i  (mem_ready_i),
    .alu_result_o (alu_result_o),
    .halt_o       (halt_o)
`ifdef MIPS_MC_PERF_EN
    ,
    .cycle_count_o(cycle_count_o),
    .instr_count_o(instr_count_o)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:15];
  int          data_wait = 0;
  int          wait_cnt  = 0;
  int          errors    = 0;
  int          checks    = 0;

  // Memory model: text lives below 0x1000_0000, data at 0x1000_8000 upward
  always @(negedge clk) begin
    if (!mem_req_o) begin
      wait_cnt    = 0;
      mem_ready_i = 1'b0;
    end else if ((mem_addr_o[31:28] != 4'h0) && (wait_cnt < data_wait)) begin
      wait_cnt    = wait_cnt + 1;
      mem_ready_i = 1'b0;
    end else begin
      wait_cnt    = 0;
      mem_ready_i = 1'b1;
      if (mem_addr_o[31:28] == 4'h0) begin
        mem_rdata_i = imem[mem_addr_o[7:2]];
      end else begin
        if (mem_we_o) dmem[mem_addr_o[5:2]] = mem_wdata_o;
        mem_rdata_i = dmem[mem_addr_o[5:2]];
      end
    end
  end

  // Fetch log and data-request counter
  int          cyc    = 0;
  int          fn     = 0;
  int          dreq   = 0;
  logic        prev_f = 1'b0;
  logic [31:0] fa [0:63];
  int          fc [0:63];

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (mem_req_o && (mem_addr_o[31:28] == 4'h0)) begin
      if (!prev_f && (fn < 64)) begin
        fa[fn] = mem_addr_o;
        fc[fn] = cyc;
        fn     = fn + 1;
      end
      prev_f = 1'b1;
    end else begin
      prev_f = 1'b0;
    end
    if (mem_req_o && (mem_addr_o[31:28] != 4'h0)) dreq = dreq + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_fetches(input int n);
    int k = 0;
    while ((fn < n) && (k < 3000)) begin
      @(negedge clk);
      k++;
    end
    if (fn < n) check("fetch_timeout", fn, n);
  endtask

  logic [31:0] exp_a [0:21];
  int          exp_g [0:21];
  int          snap_f, snap_d, k;

  initial begin
    reset       = 1'b0;
    mem_ready_i = 1'b0;
    mem_rdata_i = 32'h0;
    for (int i = 0; i < 16; i++) dmem[i] = 32'h0;
    for (int i = 0; i < 64; i++) imem[i] = c_undef;
    imem[0]  = 32'h2008_0005; // addi $8,$0,5
    imem[1]  = 32'h2009_FFFD; // addi $9,$0,-3
    imem[2]  = 32'h0109_5020; // add  $10,$8,$9
    imem[3]  = 32'hAF88_0000; // sw   $8,0($28)
    imem[4]  = 32'h0C10_0018; // jal  0x00400060
    imem[5]  = 32'h8F8B_0000; // lw   $11,0($28)
    imem[6]  = 32'h3C0E_1234; // lui  $14,0x1234
    imem[7]  = 32'h35CE_8001; // ori  $14,$14,0x8001
    imem[8]  = 32'h0128_782A; // slt  $15,$9,$8
    imem[9]  = 32'h0008_8100; // sll  $16,$8,4
    imem[10] = 32'h0109_8827; // nor  $17,$8,$9
    imem[11] = 32'h0109_9022; // sub  $18,$8,$9
    imem[12] = 32'h01C8_9824; // and  $19,$14,$8
    imem[13] = 32'h010E_A025; // or   $20,$8,$14
    imem[14] = 32'h200D_0002; // addi $13,$0,2
    imem[15] = 32'h218C_0001; // addi $12,$12,1
    imem[16] = 32'h158D_FFFE; // bne  $12,$13,-2
    imem[17] = 32'h118D_0001; // beq  $12,$13,+1
    imem[24] = 32'h03E0_0008; // jr   $31 (at 0x00400060)

    exp_a = '{32'h0040_0000, 32'h0040_0004, 32'h0040_0008, 32'h0040_000C,
              32'h0040_0010, 32'h0040_0060, 32'h0040_0014, 32'h0040_0018,
              32'h0040_001C, 32'h0040_0020, 32'h0040_0024, 32'h0040_0028,
              32'h0040_002C, 32'h0040_0030, 32'h0040_0034, 32'h0040_0038,
              32'h0040_003C, 32'h0040_0040, 32'h0040_003C, 32'h0040_0040,
              32'h0040_0044, 32'h0040_004C};
    exp_g = '{0, 4, 4, 4, 7, 3, 3, 8, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 3, 4, 3, 3};

    // ---- reset state
    repeat (3) @(negedge clk);
    check("rst_req",    {31'h0, mem_req_o}, 32'h0);
    check("rst_we",     {31'h0, mem_we_o},  32'h0);
    check("rst_halt",   {31'h0, halt_o},    32'h0);
    check("rst_addr",   mem_addr_o,   32'h0);
    check("rst_wdata",  mem_wdata_o,  32'h0);
    check("rst_alu",    alu_result_o, 32'h0);
    check("rst_pc",     dut.pc_q,     c_reset_pc);
    check("rst_gp",     dut.rf_q[28], c_gp);
    check("rst_sp",     dut.rf_q[29], c_sp);
    check("rst_r31",    dut.rf_q[31], 32'h0);

    // ---- release: one INIT cycle, then the first fetch
    reset = 1'b1;
    #1;
    check("init_req", {31'h0, mem_req_o}, 32'h0);
    @(posedge clk);
    #1;
    check("first_req",  {31'h0, mem_req_o}, 32'h1);
    check("first_we",   {31'h0, mem_we_o},  32'h0);
    check("first_addr", mem_addr_o, c_reset_pc);
    data_wait = 3;

    // ---- addi/addi/add
    wait_fetches(4);
    check("add_alu", alu_result_o, 32'd2);
    check("r8",      dut.rf_q[8],  32'd5);
    check("r9",      dut.rf_q[9],  32'hFFFF_FFFD);
    check("r10",     dut.rf_q[10], 32'd2);

    // ---- sw with three wait states: request held for four cycles
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("sw_req",   {31'h0, mem_req_o}, 32'h1);
      check("sw_we",    {31'h0, mem_we_o},  32'h1);
      check("sw_addr",  mem_addr_o,  c_gp);
      check("sw_wdata", mem_wdata_o, 32'd5);
      @(negedge clk);
    end
    check("sw_done_we",   {31'h0, mem_we_o}, 32'h0);
    check("sw_done_addr", mem_addr_o, 32'h0040_0010);
    check("sw_mem",       dmem[0], 32'd5);

    // ---- rest of the program: fetch order and per-instruction cycle counts
    wait_fetches(22);
    for (int i = 0; i < 22; i++) begin
      check("fetch_addr", fa[i], exp_a[i]);
      if (i > 0) check("fetch_gap", fc[i] - fc[i-1], exp_g[i]);
    end
    check("r31_jal", dut.rf_q[31], 32'h0040_0014);
    check("r11_lw",  dut.rf_q[11], 32'd5);
    check("r14_ori", dut.rf_q[14], 32'h1234_8001);
    check("r15_slt", dut.rf_q[15], 32'd1);
    check("r16_sll", dut.rf_q[16], 32'h50);
    check("r17_nor", dut.rf_q[17], 32'd2);
    check("r18_sub", dut.rf_q[18], 32'd8);
    check("r19_and", dut.rf_q[19], 32'd1);
    check("r20_or",  dut.rf_q[20], 32'h1234_8005);
    check("r12_cnt", dut.rf_q[12], 32'd2);

    // ---- undefined opcode at 0x0040004C halts
    repeat (4) @(negedge clk);
    check("undef_halt", {31'h0, halt_o},    32'h1);
    check("undef_req",  {31'h0, mem_req_o}, 32'h0);
    snap_f = fn;
    snap_d = dreq;
    repeat (10) @(negedge clk);
    check("undef_nofetch", fn,   snap_f);
    check("undef_nodata",  dreq, snap_d);
    check("undef_halt2",   {31'h0, halt_o}, 32'h1);

    // ---- misaligned lw $11,2($28) halts without a data request
    reset = 1'b0;
    #1;
    check("rst_clr_halt", {31'h0, halt_o}, 32'h0);
    data_wait = 0;
    imem[0]   = 32'h8F8B_0002;
    @(negedge clk);
    reset  = 1'b1;
    snap_f = fn;
    snap_d = dreq;
    repeat (12) @(negedge clk);
    check("mis_fetches", fn,   snap_f + 1);
    check("mis_nodata",  dreq, snap_d);
    check("mis_halt",    {31'h0, halt_o},    32'h1);
    check("mis_req",     {31'h0, mem_req_o}, 32'h0);
    check("mis_r11",     dut.rf_q[11], 32'h0);

    // ---- reset in the middle of a stalled lw
    reset     = 1'b0;
    data_wait = 10;
    imem[0]   = 32'h8F8B_0000;
    @(negedge clk);
    reset = 1'b1;
    k = 0;
    while (!(mem_req_o && (mem_addr_o == c_gp)) && (k < 50)) begin
      @(negedge clk);
      k++;
    end
    check("lw_wait_seen", mem_addr_o, c_gp);
    repeat (2) @(negedge clk);
    check("lw_still_req", {31'h0, mem_req_o}, 32'h1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_req",  {31'h0, mem_req_o}, 32'h0);
    check("async_addr", mem_addr_o, 32'h0);
    check("async_we",   {31'h0, mem_we_o},  32'h0);
    data_wait = 0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("restart_init", {31'h0, mem_req_o}, 32'h0);
    @(posedge clk);
    #1;
    check("restart_req",  {31'h0, mem_req_o}, 32'h1);
    check("restart_addr", mem_addr_o, c_reset_pc);
    check("restart_halt", {31'h0, halt_o},    32'h0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
